// File: rtl/toggle_stream_decoder.sv
// Purpose: toggle-line receiver; recovers bits (line XOR previous level), hunts a sync word, deserializes framed words LSB first.
// Latency: dec_bit is combinational; out_valid rises 1 cycle after the symbol carrying a word's last bit.
// Backpressure: single-entry output buffer; a word completing while the buffer is full is dropped and overrun pulses.
//
// Ports:
//   clk        - clock, all logic on posedge
//   reset      - synchronous active-low reset
//   line_in    - encoded line level
//   line_valid - line_in carries a new symbol this cycle
//   dec_bit    - decoded bit for the current symbol (0 when line_valid=0)
//   out_data   - received word, stable while out_valid=1
//   out_valid  - word available
//   out_ready  - consumer accepts the word when out_valid & out_ready
//   in_frame   - 1 while receiving frame words
//   overrun    - one-cycle pulse when a completed word is dropped
module toggle_stream_decoder #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(8'hA5),
    parameter int                FRAME_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_in,
    input  logic              line_valid,
    output logic              dec_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              in_frame,
    output logic              overrun
);

    localparam int BC_W = $clog2(DATA_W);
    localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_WORDS - 1);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic              r_prev_line;
    logic [DATA_W-1:0] r_sr;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_overrun;

    logic              w_dec;
    logic [DATA_W-1:0] w_sr_next;
    logic              w_word_done;
    logic              w_last_word;

    assign w_dec     = line_in ^ r_prev_line;
    // New bit enters at the MSB so after DATA_W shifts the first-received bit sits at the LSB.
    assign w_sr_next = {w_dec, r_sr[DATA_W-1:1]};

    // w_sr_next holds exactly the DATA_W bits of the current word when this is true.
    assign w_word_done = line_valid && (r_state == ST_RECV) && (r_bit_cnt == BC_LAST);
    assign w_last_word = w_word_done && (r_word_cnt == WC_LAST);

    // Framing FSM and deserializer; everything freezes when no symbol arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_line <= 1'b0;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_state     <= ST_HUNT;
        end else if (line_valid) begin
            r_prev_line <= line_in;
            r_sr        <= w_sr_next;
            case (r_state)
                ST_HUNT: begin
                    // Sliding match: checked on every bit, no alignment required.
                    if (w_sr_next == SYNC_WORD) begin
                        r_state    <= ST_RECV;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                default: begin
                    if (r_bit_cnt == BC_LAST) begin
                        r_bit_cnt <= '0;
                        if (w_last_word) begin
                            // Clearing the shifter keeps frame tail bits out of the next sync hunt.
                            r_sr       <= '0;
                            r_word_cnt <= '0;
                            r_state    <= ST_HUNT;
                        end else begin
                            r_word_cnt <= r_word_cnt + WC_W'(1);
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
            endcase
        end
    end

    // Single-entry output buffer. A full buffer being drained this same cycle can
    // still take the new word; otherwise the new word is lost and flagged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_word_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_data  <= w_sr_next;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dec_bit   = line_valid & w_dec;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign in_frame  = (r_state == ST_RECV);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_stream_decoder.sv
// Purpose: self-checking bench for toggle_stream_decoder against a bit-list/queue reference model.
// Latency: expected outputs are compared 1 time unit after each rising edge; dec_bit mid-cycle.
// Backpressure: out_ready driven per scenario (held high, held low, or random per cycle).
module tb_toggle_stream_decoder;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       line_in    = 1'b0;
    logic       line_valid = 1'b0;
    logic       out_ready  = 1'b0;
    logic       dec_bit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       in_frame;
    logic       overrun;

    toggle_stream_decoder #(
        .DATA_W      (8),
        .SYNC_WORD   (8'hA5),
        .FRAME_WORDS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .line_in    (line_in),
        .line_valid (line_valid),
        .dec_bit    (dec_bit),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_frame   (in_frame),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic v;
        logic l;
    } sym_t;

    sym_t       stim[$];
    logic [7:0] got[$];
    bit         tx_level;

    // Reference model: decoded-bit window as a queue, word built bit by bit,
    // buffer tracked as (valid, data) with the accept/drop rules.
    bit         m_prev;
    bit         m_recv;
    int         m_bits;
    int         m_wcnt;
    logic [7:0] m_word;
    bit         m_win[$];
    bit         m_ov;
    bit         m_ovr;
    logic [7:0] m_od;
    logic       obs_db;
    logic       exp_db;

    task automatic model_reset();
        m_prev = 0; m_recv = 0; m_bits = 0; m_wcnt = 0; m_word = '0;
        m_win.delete();
        repeat (8) m_win.push_back(1'b0);
        m_ov = 0; m_ovr = 0; m_od = '0;
        tx_level = 0;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            reset      = 1'b0;
            line_valid = 1'($urandom);
            line_in    = 1'($urandom);
        end
        @(negedge clk);
        reset      = 1'b1;
        line_valid = 1'b0;
        model_reset();
        stim.delete();
        got.delete();
    endtask

    task automatic push_sym(input logic v, input logic l);
        sym_t s;
        s.v = v;
        s.l = l;
        stim.push_back(s);
    endtask

    // Toggle-encode a byte LSB first, optionally with idle gaps after each symbol.
    task automatic push_word(input logic [7:0] b, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            tx_level = tx_level ^ b[i];
            push_sym(1'b1, tx_level);
            repeat ($urandom_range(maxgap, 0)) push_sym(1'b0, 1'($urandom));
        end
    endtask

    task automatic drive_cycle(input logic v, input logic l, input logic r);
        bit         d;
        bit         done;
        logic [7:0] w;
        int         val;
        @(negedge clk);
        line_valid = v;
        line_in    = l;
        out_ready  = r;
        #1;
        obs_db = dec_bit;
        exp_db = v & (l ^ m_prev);
        done = 0;
        w    = '0;
        if (v) begin
            d      = l ^ m_prev;
            m_prev = l;
            if (!m_recv) begin
                m_win.push_back(d);
                void'(m_win.pop_front());
                val = 0;
                foreach (m_win[i]) val += int'(m_win[i]) << i;
                if (val == 'hA5) begin
                    m_recv = 1; m_bits = 0; m_word = '0; m_wcnt = 0;
                end
            end else begin
                m_word[m_bits] = d;
                m_bits++;
                if (m_bits == 8) begin
                    done   = 1;
                    w      = m_word;
                    m_bits = 0;
                    m_word = '0;
                    m_wcnt++;
                    if (m_wcnt == 4) begin
                        m_recv = 0;
                        m_wcnt = 0;
                        m_win.delete();
                        repeat (8) m_win.push_back(1'b0);
                    end
                end
            end
        end
        m_ovr = 0;
        if (done) begin
            if (!m_ov || r) begin
                m_ov = 1;
                m_od = w;
            end else begin
                m_ovr = 1;
            end
        end else if (m_ov && r) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset      = 1'b0;
            line_valid = (c == 0) ? 1'b0 : 1'($urandom);
            line_in    = 1'($urandom);
            out_ready  = 1'($urandom);
            #1;
            checks++;
            if (dec_bit !== ((c == 0) ? 1'b0 : (line_valid & line_in))) begin
                errors++;
                $display("FAIL reset_dec_bit c=%0d got %b want %b", c, dec_bit,
                         (c == 0) ? 1'b0 : (line_valid & line_in));
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_frame, overrun, out_data} !== 11'b0) begin
                errors++;
                $display("FAIL reset_outputs c=%0d got vld=%b frm=%b ovr=%b dat=%h want all 0",
                         c, out_valid, in_frame, overrun, out_data);
            end
        end
        @(negedge clk);
        reset      = 1'b1;
        line_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_sync_one_word();
        bit lv[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        do_reset(2);
        foreach (lv[i]) begin
            push_sym(1'b1, lv[i]);
            tx_level = lv[i];
        end
        push_word(8'h3C, 0);
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b1);
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL sync_word k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
            if (k == 7) begin
                checks++;
                if (in_frame !== 1'b1) begin
                    errors++;
                    $display("FAIL sync_in_frame got %b want 1", in_frame);
                end
            end
            if (k == 15) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
                    errors++;
                    $display("FAIL sync_first_word got vld=%b dat=%h want vld=1 dat=3c", out_valid, out_data);
                end
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset(2);
        push_word(8'hA5, 0);
        for (int i = 1; i <= 4; i++) push_word(8'(i), 0);
        push_word(8'h00, 0);
        push_word(8'hFF, 0);
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b1);
            if (out_valid) got.push_back(out_data);
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL full_frame k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
            if (k == 39) begin
                checks++;
                if (in_frame !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_end_in_frame got %b want 0", in_frame);
                end
            end
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03 || got[3] !== 8'h04) begin
            errors++;
            $display("FAIL frame_words got %0d words (first %h) want 4 words 01..04", got.size(),
                     (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_backpressure();
        int ovr_cnt = 0;
        do_reset(2);
        push_word(8'hA5, 0);
        push_word(8'h11, 0);
        push_word(8'h22, 0);
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b0);
            if (overrun) ovr_cnt++;
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL backpressure k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
        end
        checks++;
        if (ovr_cnt != 1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL bp_hold got ovr_pulses=%0d vld=%b dat=%h want 1 1 11", ovr_cnt, out_valid, out_data);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got vld=%b dat=%h ovr=%b want 0 11 0", out_valid, out_data, overrun);
        end
    endtask

    task automatic test_gapped();
        do_reset(2);
        push_word(8'hA5, 3);
        for (int i = 1; i <= 4; i++) push_word(8'(i), 3);
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b1);
            if (out_valid) got.push_back(out_data);
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL gapped k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03 || got[3] !== 8'h04 || in_frame !== 1'b0) begin
            errors++;
            $display("FAIL gapped_words got %0d words frm=%b want 4 words 01..04 frm=0", got.size(), in_frame);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset(2);
        push_word(8'hA5, 0);
        push_word(8'h01, 0);
        for (int i = 0; i < 5; i++) begin
            tx_level = tx_level ^ ((i == 1) ? 1'b1 : 1'b0);
            push_sym(1'b1, tx_level);
        end
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b1);
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL midframe_pre k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
        end
        @(negedge clk);
        reset      = 1'b0;
        line_valid = 1'b1;
        line_in    = ~line_in;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_frame, overrun, out_data} !== 11'b0) begin
            errors++;
            $display("FAIL midframe_reset got vld=%b frm=%b ovr=%b dat=%h want all 0", out_valid, in_frame, overrun, out_data);
        end
        @(negedge clk);
        reset      = 1'b1;
        line_valid = 1'b0;
        model_reset();
        stim.delete();
        push_word(8'hA5, 0);
        push_word(8'h5A, 0);
        push_word(8'h6B, 0);
        push_word(8'h7C, 0);
        push_word(8'h8D, 0);
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'b1);
            if (out_valid) got.push_back(out_data);
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL midframe_post k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'h5A || got[3] !== 8'h8D || in_frame !== 1'b0) begin
            errors++;
            $display("FAIL midframe_restart got %0d words frm=%b want 4 words 5a..8d frm=0", got.size(), in_frame);
        end
    endtask

    task automatic test_random();
        do_reset(2);
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 6; j++) push_sym(1'($urandom), 1'($urandom));
            tx_level = stim[$].l;
            for (int j = stim.size() - 1; j >= 0; j--) begin
                if (stim[j].v) begin
                    tx_level = stim[j].l;
                    break;
                end
            end
            push_word(8'hA5, 2);
            for (int i = 0; i < 4; i++) push_word(8'($urandom), 2);
        end
        foreach (stim[k]) begin
            drive_cycle(stim[k].v, stim[k].l, 1'($urandom));
            checks++;
            if (obs_db !== exp_db || out_valid !== m_ov || out_data !== m_od || in_frame !== m_recv || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random k=%0d got db=%b vld=%b dat=%h frm=%b ovr=%b want db=%b vld=%b dat=%h frm=%b ovr=%b",
                         k, obs_db, out_valid, out_data, in_frame, overrun, exp_db, m_ov, m_od, m_recv, m_ovr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync_one_word();
        test_full_frame();
        test_backpressure();
        test_gapped();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
